// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter for the rv32i multicycle core: the fetch and load/store
// ports share one memory through a fixed ACCESS / WAIT / RESP schedule.
`timescale 1ns/1ps
module rv32i_mem_arbiter #(
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned ARB_MODE        = 0,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter logic [31:0] RESET_ADDR      = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int unsigned SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  // Counter reloads to READ_LATENCY-1 so the read word is captured on the last WAIT cycle.
  localparam logic [1:0]    WAIT_INIT  = 2'(READ_LATENCY - 1);

  state_t        state, state_nxt;
  logic          cur_we;
  logic [1:0]    wait_cnt;
  logic [SW-1:0] streak;
  logic          pick_data;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    pick_data  = 1'b0;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    if_ack     = 1'b0;
    d_ack      = 1'b0;
    mem_wr_ena = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (ena && (if_req || d_req)) begin
          if (!if_req)
            pick_data = 1'b1;
          else if (d_req)
            pick_data = (ARB_MODE == 1) ? !owner : (streak != STREAK_MAX);
          d_gnt     = pick_data;
          if_gnt    = !pick_data;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_wr_ena = cur_we;
        state_nxt  = cur_we ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == '0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if_ack    = !owner;
        d_ack     = owner;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr    <= RESET_ADDR;
      mem_wr_data <= '0;
      owner       <= 1'b1;
      cur_we      <= 1'b0;
      wait_cnt    <= '0;
      streak      <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
    end else begin
      if (if_gnt) begin
        mem_addr <= if_addr;
        owner    <= 1'b0;
        cur_we   <= 1'b0;
        streak   <= '0;
      end
      if (d_gnt) begin
        mem_addr    <= d_addr;
        mem_wr_data <= d_wdata;
        owner       <= 1'b1;
        cur_we      <= d_we;
        // Streak only grows while fetch is being made to wait.
        if (!if_req)
          streak <= '0;
        else if (streak != STREAK_MAX)
          streak <= streak + 1'b1;
      end
      if (state == ST_ACCESS)
        wait_cnt <= WAIT_INIT;
      if (state == ST_WAIT) begin
        if (wait_cnt == '0) begin
          if (owner) d_rdata  <= mem_rd_data;
          else       if_rdata <= mem_rd_data;
        end else begin
          wait_cnt <= wait_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: dut_a is fixed priority with L=1, dut_b is
// round-robin with L=3; both share the request inputs and each has its own memory.
`timescale 1ns/1ps
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, ena, if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic        if_gnt_a, if_ack_a, d_gnt_a, d_ack_a, mem_wr_ena_a, busy_a, owner_a;
  logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wr_data_a, mem_rd_data_a;
  logic        if_gnt_b, if_ack_b, d_gnt_b, d_ack_b, mem_wr_ena_b, busy_b, owner_b;
  logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wr_data_b, mem_rd_data_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(.READ_LATENCY(1), .ARB_MODE(0), .MAX_DATA_STREAK(4), .RESET_ADDR(32'h0)) dut_a (
    .clk(clk), .rst(rst), .ena(ena),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a), .if_ack(if_ack_a), .if_rdata(if_rdata_a),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_a), .d_ack(d_ack_a), .d_rdata(d_rdata_a),
    .mem_addr(mem_addr_a), .mem_wr_data(mem_wr_data_a), .mem_wr_ena(mem_wr_ena_a),
    .mem_rd_data(mem_rd_data_a), .busy(busy_a), .owner(owner_a)
  );

  rv32i_mem_arbiter #(.READ_LATENCY(3), .ARB_MODE(1), .MAX_DATA_STREAK(4), .RESET_ADDR(32'h0)) dut_b (
    .clk(clk), .rst(rst), .ena(ena),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b), .if_ack(if_ack_b), .if_rdata(if_rdata_b),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_b), .d_ack(d_ack_b), .d_rdata(d_rdata_b),
    .mem_addr(mem_addr_b), .mem_wr_data(mem_wr_data_b), .mem_wr_ena(mem_wr_ena_b),
    .mem_rd_data(mem_rd_data_b), .busy(busy_b), .owner(owner_b)
  );

  // Memory models: synchronous write, read pipeline of READ_LATENCY stages.
  // Word 0x10 reads as a fixed instruction so no array preload is needed.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];

  function automatic logic [31:0] read_word(input logic [31:0] addr, input logic [31:0] stored);
    return (addr == 32'h10) ? 32'h0050_0093 : stored;
  endfunction

  always @(posedge clk) begin
    if (mem_wr_ena_a) mem_a[mem_addr_a[9:2]] <= mem_wr_data_a;
    if (mem_wr_ena_b) mem_b[mem_addr_b[9:2]] <= mem_wr_data_b;
    pipe_a    <= read_word(mem_addr_a, mem_a[mem_addr_a[9:2]]);
    pipe_b[0] <= read_word(mem_addr_b, mem_b[mem_addr_b[9:2]]);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign mem_rd_data_a = pipe_a;
  assign mem_rd_data_b = pipe_b[2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; ena = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Waits for each of n grants (bounded) and checks whether it went to data.
  task automatic grant_seq(input bit use_b, input int n, input logic [7:0] exp_data, input string tag);
    int waited;
    for (int k = 0; k < n; k++) begin
      waited = 0;
      @(negedge clk);
      while (!(use_b ? (if_gnt_b || d_gnt_b) : (if_gnt_a || d_gnt_a)) && waited < 16) begin
        nxt();
        @(negedge clk);
        waited++;
      end
      check($sformatf("%s_seen%0d", tag, k), 32'(waited < 16), 32'd1);
      check($sformatf("%s_data%0d", tag, k), 32'(use_b ? d_gnt_b : d_gnt_a), 32'(exp_data[k]));
      nxt();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_ack;

    // Reset state, then a single fetch on dut_a (L=1).
    do_reset();
    @(negedge clk);
    check("rst_busy", busy_a, 1'b0);
    check("rst_owner", owner_a, 1'b1);
    check("rst_mem_addr", mem_addr_a, 32'h0);
    check("rst_wr_ena", mem_wr_ena_a, 1'b0);
    check("rst_if_rdata", if_rdata_a, 32'h0);
    check("rst_owner_b", owner_b, 1'b1);
    nxt();
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("f_if_gnt", if_gnt_a, 1'b1);
    check("f_d_gnt", d_gnt_a, 1'b0);
    nxt(); if_req = 1'b0;
    @(negedge clk);
    check("f_mem_addr", mem_addr_a, 32'h10);
    check("f_busy1", busy_a, 1'b1);
    check("f_owner", owner_a, 1'b0);
    nxt(); @(negedge clk);
    check("f_ack_early", if_ack_a, 1'b0);
    nxt(); @(negedge clk);
    check("f_ack", if_ack_a, 1'b1);
    check("f_rdata", if_rdata_a, 32'h0050_0093);
    check("f_busy3", busy_a, 1'b1);
    nxt(); @(negedge clk);
    check("f_ack_done", if_ack_a, 1'b0);
    check("f_busy_done", busy_a, 1'b0);
    check("f_rdata_hold", if_rdata_a, 32'h0050_0093);

    // Store then readback load on dut_a.
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("s_d_gnt", d_gnt_a, 1'b1);
    check("s_wr_ena_t", mem_wr_ena_a, 1'b0);
    nxt(); d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("s_wr_ena", mem_wr_ena_a, 1'b1);
    check("s_addr", mem_addr_a, 32'h100);
    check("s_wdata", mem_wr_data_a, 32'hDEAD_BEEF);
    check("s_ack_early", d_ack_a, 1'b0);
    nxt(); @(negedge clk);
    check("s_wr_ena_off", mem_wr_ena_a, 1'b0);
    check("s_ack", d_ack_a, 1'b1);
    nxt();
    d_req = 1'b1;
    @(negedge clk);
    check("l_d_gnt", d_gnt_a, 1'b1);
    nxt(); d_req = 1'b0;
    @(negedge clk);
    check("l_wr_ena", mem_wr_ena_a, 1'b0);
    nxt(); nxt(); @(negedge clk);
    check("l_ack", d_ack_a, 1'b1);
    check("l_rdata", d_rdata_a, 32'hDEAD_BEEF);
    check("l_if_rdata_untouched", if_rdata_a, 32'h0);

    // Fixed priority with both requests held: D,D,D,D,F,D.
    do_reset();
    if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_addr = 32'h200;
    grant_seq(1'b0, 6, 8'b0010_1111, "prio");
    if_req = 1'b0; d_req = 1'b0;

    // Round robin with both held after reset: F,D,F,D; then lone data always wins.
    do_reset();
    if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_addr = 32'h200;
    grant_seq(1'b1, 4, 8'b0000_1010, "rr");
    if_req = 1'b0;
    grant_seq(1'b1, 2, 8'b0000_0011, "lone");
    d_req = 1'b0;

    // L=3 on dut_b: store, then load with ena dropped during WAIT.
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h180; d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("e_st_gnt", d_gnt_b, 1'b1);
    nxt(); d_req = 1'b0; d_we = 1'b0;
    nxt(); @(negedge clk);
    check("e_st_ack", d_ack_b, 1'b1);
    nxt();
    d_req = 1'b1;
    @(negedge clk);
    check("e_ld_gnt", d_gnt_b, 1'b1);
    nxt(); d_req = 1'b0;
    nxt(); ena = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("e_no_gnt_wait", if_gnt_b, 1'b0);
    nxt(); nxt(); @(negedge clk);
    check("e_ack_early", d_ack_b, 1'b0);
    nxt(); @(negedge clk);
    check("e_ack", d_ack_b, 1'b1);
    check("e_rdata", d_rdata_b, 32'hCAFE_F00D);
    nxt(); @(negedge clk);
    check("e_idle", busy_b, 1'b0);
    check("e_no_gnt_idle", if_gnt_b, 1'b0);
    nxt(); ena = 1'b1;
    @(negedge clk);
    check("e_gnt_resume", if_gnt_b, 1'b1);
    nxt(); if_req = 1'b0;
    repeat (4) nxt();
    @(negedge clk);
    check("e_if_ack", if_ack_b, 1'b1);
    check("e_if_rdata", if_rdata_b, 32'h0050_0093);

    // Reset asserted mid-WAIT on dut_b abandons the fetch without an ack.
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("r_gnt", if_gnt_b, 1'b1);
    nxt(); if_req = 1'b0;
    nxt(); @(negedge clk);
    check("r_busy_wait", busy_b, 1'b1);
    rst = 1'b0;
    #1;
    check("r_busy", busy_b, 1'b0);
    check("r_owner", owner_b, 1'b1);
    check("r_mem_addr", mem_addr_b, 32'h0);
    check("r_if_rdata", if_rdata_b, 32'h0);
    seen_ack = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen_ack = seen_ack | if_ack_b;
    end
    check("r_no_ack", seen_ack, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    if_req = 1'b1;
    @(negedge clk);
    check("r_regnt", if_gnt_b, 1'b1);
    nxt(); if_req = 1'b0;
    repeat (4) nxt();
    @(negedge clk);
    check("r_ack", if_ack_b, 1'b1);
    check("r_rdata", if_rdata_b, 32'h0050_0093);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
